// File: rtl/sreg_pkg.sv
// Shared types for the shift-register frame sequencer.
// Defines controller opcodes, sequencer modes and the word width.
package sreg_pkg;

    localparam int SREG_W = 42;

    typedef enum logic [2:0] {
        PIX_WRITE         = 3'd0,
        PIX_READ          = 3'd1,
        PIX_READ_END      = 3'd2,
        WRITE_PCLK_0      = 3'd3,
        WRITE_PCLK_1      = 3'd4,
        WRITE_FULL_PCLK_0 = 3'd5,
        WRITE_FULL_PCLK_1 = 3'd6,
        SREG_READ         = 3'd7
    } opcode_e;

    typedef enum logic [1:0] {
        MODE_CFG_WRITE = 2'd0,
        MODE_READOUT   = 2'd1,
        MODE_SREG_DUMP = 2'd2,
        MODE_ILLEGAL   = 2'd3
    } mode_e;

endpackage

// File: rtl/sreg_cmd_if.sv
// Command handshake to the shift-register controller: valid/ready
// acceptance in ISSUE, completion detect in WAIT, optional watchdog.
// Ports: issue/wait_st state flags in; accept/complete/timeout out.
// Optional feature macro: SREG_SEQ_TIMEOUT_EN (watchdog counter).
module sreg_cmd_if #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic issue,
    input  logic wait_st,
    input  logic abort,
    input  logic sc_cmd_ready,
    output logic sc_cmd_valid,
    output logic accept,
    output logic complete,
    output logic timeout
);

    // Abort withdraws the request in the same cycle, so an abort
    // cycle can never also be an acceptance cycle.
    assign sc_cmd_valid = issue && !abort;
    assign accept       = sc_cmd_valid && sc_cmd_ready;
    assign complete     = wait_st && sc_cmd_ready;

`ifdef SREG_SEQ_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             active;

    assign active  = issue || wait_st;
    assign timeout = active &&
                     (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

    // Any leaving event restarts the count, so every entry
    // into ISSUE or WAIT starts from zero.
    always_comb begin
        cnt_d = '0;
        if (active && !accept && !complete && !timeout) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic unused_ok;

    assign timeout   = 1'b0;
    assign unused_ok = ^{clk, rst, TIMEOUT_CYC[0]};
`endif

endmodule

// File: rtl/sreg_seq.sv
// Frame sequencer: expands a start request into per-row controller
// commands, fetches config words, returns read-back words.
// Ports: host start/mode/abort/status, cfg RAM, readout, controller.
// Optional feature macro: SREG_SEQ_TIMEOUT_EN (command watchdog).
module sreg_seq
    import sreg_pkg::*;
#(
    parameter int N_ROWS      = 16,
    parameter int ROW_W       = $clog2(N_ROWS),
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic              abort,
    input  logic [SREG_W-1:0] glob_cfg,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              aborted,
    output logic              cfg_rd_en,
    output logic [ROW_W-1:0]  cfg_addr,
    input  logic [SREG_W-1:0] cfg_rdata,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [ROW_W-1:0]  rd_row,
    output logic [SREG_W-1:0] rd_data,
    output logic              sc_cmd_valid,
    output logic [2:0]        sc_cmd,
    output logic [SREG_W-1:0] sc_data,
    input  logic              sc_cmd_ready,
    input  logic [SREG_W-1:0] sc_data_out
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_LOAD, S_ISSUE,
        S_WAIT, S_OUT, S_FINISH
    } state_e;

    state_e            state_q, state_d;
    mode_e             mode_q, mode_d;
    opcode_e           cmd_q, cmd_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [SREG_W-1:0] data_q, data_d;
    logic [SREG_W-1:0] rdat_q, rdat_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;
    logic              abt_q, abt_d;
    logic              abt_pend_q, abt_pend_d;
    logic              glob_q, glob_d;

    logic  accept, complete, timeout;
    logic  last_row, pen_row;
    mode_e mode_in;

    assign mode_in  = mode_e'(mode);
    assign last_row = (row_q == ROW_W'(N_ROWS - 1));
    assign pen_row  = (row_q == ROW_W'(N_ROWS - 2));

    sreg_cmd_if #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_cmd_if (
        .clk          (clk),
        .rst          (rst),
        .issue        (state_q == S_ISSUE),
        .wait_st      (state_q == S_WAIT),
        .abort        (abort),
        .sc_cmd_ready (sc_cmd_ready),
        .sc_cmd_valid (sc_cmd_valid),
        .accept       (accept),
        .complete     (complete),
        .timeout      (timeout)
    );

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        cmd_d      = cmd_q;
        row_d      = row_q;
        data_d     = data_q;
        rdat_d     = rdat_q;
        busy_d     = busy_q;
        err_d      = err_q;
        abt_d      = abt_q;
        abt_pend_d = abt_pend_q;
        glob_d     = glob_q;
        unique case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    mode_d     = mode_in;
                    row_d      = '0;
                    err_d      = 1'b0;
                    abt_d      = 1'b0;
                    abt_pend_d = 1'b0;
                    glob_d     = 1'b0;
                    unique case (mode_in)
                        MODE_CFG_WRITE: begin
                            busy_d  = 1'b1;
                            state_d = S_FETCH;
                        end
                        MODE_READOUT: begin
                            busy_d  = 1'b1;
                            cmd_d   = PIX_READ;
                            state_d = S_ISSUE;
                        end
                        MODE_SREG_DUMP: begin
                            busy_d  = 1'b1;
                            cmd_d   = SREG_READ;
                            state_d = S_ISSUE;
                        end
                        MODE_ILLEGAL: begin
                            err_d   = 1'b1;
                            state_d = S_FINISH;
                        end
                    endcase
                end
            end
            S_FETCH: begin
                if (abort) begin
                    abt_d   = 1'b1;
                    state_d = S_FINISH;
                end else begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (abort) begin
                    abt_d   = 1'b1;
                    state_d = S_FINISH;
                end else begin
                    data_d  = cfg_rdata;
                    cmd_d   = PIX_WRITE;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (accept) begin
                    state_d = S_WAIT;
                end else if (abort) begin
                    abt_d   = 1'b1;
                    state_d = S_FINISH;
                end else if (timeout) begin
                    err_d   = 1'b1;
                    state_d = S_FINISH;
                end
            end
            S_WAIT: begin
                abt_pend_d = abt_pend_q || abort;
                if (complete) begin
                    if (abt_pend_q || abort) begin
                        abt_d   = 1'b1;
                        state_d = S_FINISH;
                    end else if (mode_q != MODE_CFG_WRITE) begin
                        rdat_d  = sc_data_out;
                        state_d = S_OUT;
                    end else if (glob_q) begin
                        state_d = S_FINISH;
                    end else if (last_row) begin
                        // Rows done: close with the global word.
                        glob_d  = 1'b1;
                        cmd_d   = WRITE_PCLK_1;
                        data_d  = glob_cfg;
                        state_d = S_ISSUE;
                    end else begin
                        row_d   = row_q + ROW_W'(1);
                        state_d = S_FETCH;
                    end
                end else if (timeout) begin
                    err_d   = 1'b1;
                    state_d = S_FINISH;
                end
            end
            S_OUT: begin
                if (abort) begin
                    abt_d   = 1'b1;
                    state_d = S_FINISH;
                end else if (rd_ready) begin
                    if (mode_q == MODE_READOUT && !last_row) begin
                        row_d   = row_q + ROW_W'(1);
                        cmd_d   = pen_row ? PIX_READ_END : PIX_READ;
                        state_d = S_ISSUE;
                    end else begin
                        state_d = S_FINISH;
                    end
                end
            end
            S_FINISH: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            mode_q     <= MODE_CFG_WRITE;
            cmd_q      <= PIX_WRITE;
            row_q      <= '0;
            data_q     <= '0;
            rdat_q     <= '0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
            abt_q      <= 1'b0;
            abt_pend_q <= 1'b0;
            glob_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            cmd_q      <= cmd_d;
            row_q      <= row_d;
            data_q     <= data_d;
            rdat_q     <= rdat_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
            abt_q      <= abt_d;
            abt_pend_q <= abt_pend_d;
            glob_q     <= glob_d;
        end
    end

    assign busy      = busy_q;
    assign done      = (state_q == S_FINISH);
    assign err       = err_q;
    assign aborted   = abt_q;
    assign cfg_rd_en = (state_q == S_FETCH);
    assign cfg_addr  = row_q;
    assign rd_valid  = (state_q == S_OUT) && !abort;
    assign rd_row    = row_q;
    assign rd_data   = rdat_q;
    assign sc_cmd    = cmd_q;
    assign sc_data   = data_q;

endmodule

// File: doc/sreg_seq.md
# sreg_seq

Frame-level sequencer for the pixel shift-register controller. Accepts one start request from the host/FSM, expands it into the per-row command stream for the shift-register controller's `cmd_valid`/`cmd_ready` port, fetches row configuration words from a synchronous RAM and returns read-back words to a back-pressured readout port. Sits between the top-level FSM and the shift-register controller; only this block drives that controller's command port.

## Interface
- `N_ROWS`, 16: rows per frame; legal range 2..64.
- `ROW_W`, `$clog2(N_ROWS)`: row index width.
- `TIMEOUT_CYC`, 255: watchdog limit in cycles; used only with `SREG_SEQ_TIMEOUT_EN`.

- `clk` in 1: single clock; all logic on posedge.
- `rst` in 1: reset, synchronous, active-high.
- `start` in 1: start request; sampled only in IDLE.
- `mode` in 2: 0 CFG_WRITE, 1 READOUT, 2 SREG_DUMP, 3 illegal; sampled with `start`.
- `abort` in 1: level; stop the frame at the next safe point.
- `glob_cfg` in 42: word sent with the closing WRITE_PCLK_1 of CFG_WRITE.
- `busy` out 1: frame in progress.
- `done` out 1: one-cycle pulse at frame end.
- `err` out 1: valid with `done`; illegal mode or timeout.
- `aborted` out 1: valid with `done`; frame ended by `abort`.
- `cfg_rd_en` out 1: RAM read strobe.
- `cfg_addr` out ROW_W: RAM row address.
- `cfg_rdata` in 42: RAM data; valid the cycle after `cfg_rd_en`.
- `rd_valid` out 1: readout word valid.
- `rd_ready` in 1: readout sink ready.
- `rd_row` out ROW_W: row index of the word.
- `rd_data` out 42: read-back word.
- `sc_cmd_valid` out 1: command valid to the shift-register controller.
- `sc_cmd` out 3: opcode.
- `sc_data` out 42: command data.
- `sc_cmd_ready` in 1: controller idle/ready.
- `sc_data_out` in 42: controller read-back data.

## Operation
- States: IDLE, FETCH, LOAD, ISSUE, WAIT, OUT, FINISH.
- IDLE:
  - `start` with mode 0 goes to FETCH. Mode 1 or 2 goes to ISSUE.
  - Mode 3 goes to FINISH with `err`=1.
  - `start` and `abort` together: `start` is ignored.
- CFG_WRITE:
  - For row r = 0..N_ROWS-1: FETCH (`cfg_rd_en`=1, `cfg_addr`=r), then LOAD (capture `cfg_rdata`), then ISSUE PIX_WRITE(0) with that word, then WAIT.
  - After the last row: ISSUE WRITE_PCLK_1(4) with `glob_cfg`, then WAIT, then FINISH.
- READOUT:
  - Rows 0..N_ROWS-2 issue PIX_READ(1); row N_ROWS-1 issues PIX_READ_END(2).
  - After each WAIT: capture `sc_data_out`, then OUT with `rd_row`=r until `rd_ready`, then the next ISSUE or FINISH.
- SREG_DUMP: one SREG_READ(7), then WAIT, then OUT with `rd_row`=0, then FINISH.
- ISSUE:
  - `sc_cmd_valid`=1 with `sc_cmd`/`sc_data` stable until `sc_cmd_ready`=1.
  - Acceptance is the cycle where both are high; WAIT is entered on the next cycle.
- WAIT:
  - The controller drops ready after acceptance.
  - WAIT exits on the first cycle with `sc_cmd_ready`=1, which marks command completion.
- Row counter: ROW_W bits, cleared on start, incremented after each completed row.
  - Last-row detect is `r == N_ROWS-1`; the counter never wraps.
- Abort handling by state:
  - FETCH, LOAD, or ISSUE before acceptance: drop `sc_cmd_valid` and go to FINISH.
  - WAIT: latch the abort and go to FINISH once the command completes. An in-flight command is never cut.
  - OUT: drop `rd_valid`, discard the word, go to FINISH.
- FINISH:
  - `done`=1 for one cycle, with `err`/`aborted` valid on that cycle; then go to IDLE.
  - `err` and `aborted` are cleared on the next accepted `start`.

## Timing
- Reset values:
  - All outputs 0, including `busy`, `done`, `err`, `aborted`, `sc_cmd_valid`, `rd_valid`, and all data/address buses.
  - State is IDLE.
- Reset mid-frame: IDLE on the next cycle with `sc_cmd_valid`=0. The controller is reset in the same cycle.
- Start latency, with `start` sampled at cycle t:
  - `busy`=1 from t+1 through the `done` cycle.
  - CFG_WRITE: `cfg_rd_en` at t+1, first `sc_cmd_valid` at t+3.
  - READOUT/SREG_DUMP: first `sc_cmd_valid` at t+1.
- Completion seen at cycle w:
  - Write modes: next FETCH at w+1.
  - Read modes: `rd_valid` at w+1.
- OUT: `rd_data`/`rd_row` are held stable while `rd_valid`=1 and `rd_ready`=0. The transfer happens on the cycle where both are high.
- `done` follows the last completion (or last transfer) by exactly 1 cycle. `start` is accepted again from the cycle after `done`.

## Configuration
- `SREG_SEQ_TIMEOUT_EN` defined:
  - A counter runs in ISSUE and WAIT and is cleared on every state entry.
  - Reaching TIMEOUT_CYC drops `sc_cmd_valid` and goes to FINISH with `err`=1.
- `SREG_SEQ_TIMEOUT_EN` undefined: no counter; ISSUE and WAIT wait indefinitely.

## Structure
- Package `sreg_pkg`:
  - 3-bit opcode enum: PIX_WRITE=0, PIX_READ=1, PIX_READ_END=2, WRITE_PCLK_0=3, WRITE_PCLK_1=4, WRITE_FULL_PCLK_0=5, WRITE_FULL_PCLK_1=6, SREG_READ=7.
  - `SREG_W`=42.
  - Mode enum.
- FSM state enum stays local to `sreg_seq`.
- One sub-module: `sreg_cmd_if`, covering the ISSUE/WAIT handshake and completion detect (plus the optional watchdog).

## Test plan
- CFG_WRITE, N_ROWS=4, RAM word r = 42'h100+r, controller model 84-cycle busy:
  - PIX_WRITE carries 0x100..0x103 in order, then WRITE_PCLK_1 carries `glob_cfg`.
  - `done` exactly once, `err`=0.
- READOUT, N_ROWS=4, model returns 42'hA0+r, `rd_ready` low for 5 cycles on row 2:
  - Opcodes 1,1,1,2.
  - `rd_row` 0..3 with data 0xA0..0xA3; row 2 held stable during the stall.
- SREG_DUMP: one SREG_READ(7), one word with `rd_row`=0, then `done`.
- `start` with mode=3: `done` and `err` at t+1; no `sc_cmd_valid`, `busy`=0.
- `abort` during WAIT of row 1 in CFG_WRITE: no further commands after row 1 completes; `done` with `aborted`=1.
- With `SREG_SEQ_TIMEOUT_EN`, TIMEOUT_CYC=20, `sc_cmd_ready` stuck at 0: `sc_cmd_valid` drops after 20 cycles; `done` and `err`=1.
